// File: rtl/dm_pkg.sv
// Shared types and helpers for the dm_ext data memory: access-op encoding,
// sequencer states and alignment rules.
package dm_pkg;

  typedef enum logic [2:0] {
    OpWord  = 3'b000,
    OpHalf  = 3'b001,
    OpHalfU = 3'b010,
    OpByte  = 3'b011,
    OpByteU = 3'b100
  } dm_op_e;

  typedef enum logic {
    StClear = 1'b0,
    StReady = 1'b1
  } dm_state_e;

  localparam int unsigned WordW = 32;
  localparam int unsigned LaneW = 2;

  // Reserved encodings 101..111 behave as full-word accesses.
  function automatic dm_op_e dm_norm_op(input logic [2:0] op);
    if (op > 3'b100) return OpWord;
    return dm_op_e'(op);
  endfunction

  function automatic logic dm_misaligned(input dm_op_e op, input logic [LaneW-1:0] lane);
    logic mis;
    unique case (op)
      OpWord:          mis = (lane != 2'b00);
      OpHalf, OpHalfU: mis = lane[0];
      default:         mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Combinational load lane select with sign/zero extension; also reused by the
// WB-stage bypass path.
module dm_load_ext
  import dm_pkg::*;
(
  input  logic [WordW-1:0] word_i,
  input  logic [LaneW-1:0] lane_i,
  input  dm_op_e           op_i,
  output logic [WordW-1:0] data_o
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half     = lane_i[1] ? word_i[31:16] : word_i[15:0];
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    unique case (op_i)
      OpHalf:  data_o = {{16{half[15]}}, half};
      OpHalfU: data_o = {16'h0000, half};
      OpByte:  data_o = {{24{byte_sel[7]}}, byte_sel};
      OpByteU: data_o = {24'h000000, byte_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dm_ext.sv
// MEM-stage data memory: byte/half/word stores, extending loads, alignment
// exceptions and a clear sequencer. Define DM_TRACE_EN to print committed stores.
module dm_ext
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [ADDR_W+1:0] addr,
  input  logic [2:0]        op,
  input  logic              we,
  input  logic              re,
  input  logic [31:0]       wdata,
  input  logic [31:0]       pc,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              ready,
  output logic              exc_adel,
  output logic              exc_ades
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [WordW-1:0] mem [Depth];

  dm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              adel_q, adel_d;
  logic              ades_q, ades_d;

  logic [ADDR_W-1:0] widx;
  logic [LaneW-1:0]  lane;
  dm_op_e            op_n;
  logic              mis;
  logic              in_ready;
  logic              store_en;
  logic [31:0]       rd_word;
  logic [31:0]       ld_data;
  logic [31:0]       wmerged;

  assign widx     = addr[ADDR_W+1:2];
  assign lane     = addr[1:0];
  assign op_n     = dm_norm_op(op);
  assign mis      = dm_misaligned(op_n, lane);
  assign in_ready = (state_q == StReady);
  assign store_en = in_ready && we && !mis;
  assign rd_word  = mem[widx];

  dm_load_ext u_load_ext (
    .word_i (rd_word),
    .lane_i (lane),
    .op_i   (op_n),
    .data_o (ld_data)
  );

  always_comb begin
    wmerged = rd_word;
    unique case (op_n)
      OpHalf, OpHalfU: begin
        if (lane[1]) wmerged[31:16] = wdata[15:0];
        else         wmerged[15:0]  = wdata[15:0];
      end
      OpByte, OpByteU: wmerged[{lane, 3'b000} +: 8] = wdata[7:0];
      default:         wmerged = wdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StClear: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_W'(Depth - 1)) state_d = StReady;
      end
      StReady: begin
        if (clr) begin
          state_d = StClear;
          idx_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  // Requests are serviced only in READY, including the cycle that raises clr.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    adel_d   = 1'b0;
    ades_d   = 1'b0;
    if (in_ready) begin
      if (re) begin
        if (mis) begin
          rdata_d = '0;
          adel_d  = 1'b1;
        end else begin
          rdata_d  = ld_data;
          rvalid_d = 1'b1;
        end
      end
      if (we && mis) ades_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StClear;
      idx_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      adel_q   <= adel_d;
      ades_q   <= ades_d;
    end
  end

  // The load path samples rd_word before this update lands: read-before-write.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[idx_q] <= '0;
    end else if (store_en) begin
      mem[widx] <= wmerged;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && store_en) begin
      $display("@%08h: *%08h <= %08h", pc, 32'({widx, 2'b00}), wmerged);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign ready    = in_ready;
  assign exc_adel = adel_q;
  assign exc_ades = ades_q;

endmodule

// File: tb/tb_dm_ext.sv
// Scoreboard bench for dm_ext with ADDR_W=4: expected responses are queued at
// issue time and a negedge monitor pops and compares them.
module tb_dm_ext;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr = 1'b0;
  logic [AW+1:0] addr = '0;
  logic [2:0]    op = '0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   pc = '0;
  logic [31:0]   rdata;
  logic          rvalid, ready, exc_adel, exc_ades;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        rv;
    logic        adel;
    logic        ades;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  dm_ext #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .addr     (addr),
    .op       (op),
    .we       (we),
    .re       (re),
    .wdata    (wdata),
    .pc       (pc),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .ready    (ready),
    .exc_adel (exc_adel),
    .exc_ades (exc_ades)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && (rvalid || exc_adel || exc_ades)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_response: got rvalid=%0b adel=%0b ades=%0b rdata=%08h, required none",
                 rvalid, exc_adel, exc_ades, rdata);
      end else begin
        e = sb.pop_front();
        if (rvalid !== e.rv || exc_adel !== e.adel || exc_ades !== e.ades ||
            (e.chk_data && rdata !== e.data)) begin
          errors++;
          $display("FAIL %s: got rvalid=%0b adel=%0b ades=%0b rdata=%08h, required rvalid=%0b adel=%0b ades=%0b rdata=%08h",
                   e.name, rvalid, exc_adel, exc_ades, rdata, e.rv, e.adel, e.ades, e.data);
        end
      end
    end
  end

  task automatic push(input string n, input logic rv, input logic adel, input logic ades,
                      input logic chk_data, input logic [31:0] d);
    exp_t x;
    x.name = n; x.rv = rv; x.adel = adel; x.ades = ades; x.chk_data = chk_data; x.data = d;
    sb.push_back(x);
  endtask

  task automatic cyc(input logic w, input logic r, input logic [2:0] o,
                     input logic [AW+1:0] a, input logic [31:0] d);
    we = w; re = r; op = o; addr = a; wdata = d; pc = pc + 32'd4;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic ld(input string n, input logic [2:0] o, input logic [AW+1:0] a,
                    input logic [31:0] d);
    push(n, 1'b1, 1'b0, 1'b0, 1'b1, d);
    cyc(1'b0, 1'b1, o, a, 32'h0);
  endtask

  task automatic st(input logic [2:0] o, input logic [AW+1:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, o, a, d);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", n, act, req);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_exc", 32'({exc_adel, exc_ades}), 32'd0);
    reset = 1'b1;
    wait_ready(n);
    chk("clear_len", 32'(n), 32'd16);

    ld("lw_3c_cleared", 3'b000, 6'h3C, 32'h0000_0000);

    st(3'b000, 6'h10, 32'h1234_5678);
    st(3'b011, 6'h11, 32'hFFFF_FFAB);
    ld("lw_10_merged", 3'b000, 6'h10, 32'h1234_AB78);
    ld("lb_11", 3'b011, 6'h11, 32'hFFFF_FFAB);
    ld("lbu_11", 3'b100, 6'h11, 32'h0000_00AB);
    ld("lb_13_pos", 3'b011, 6'h13, 32'h0000_0012);
    ld("lhu_12", 3'b010, 6'h12, 32'h0000_1234);
    ld("op5_as_word", 3'b101, 6'h10, 32'h1234_AB78);

    st(3'b001, 6'h22, 32'h7777_8001);
    ld("lh_22", 3'b001, 6'h22, 32'hFFFF_8001);
    ld("lhu_22", 3'b010, 6'h22, 32'h0000_8001);
    ld("lw_20", 3'b000, 6'h20, 32'h8001_0000);

    st(3'b000, 6'h04, 32'h5566_7788);
    push("lw_06_adel", 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b1, 3'b000, 6'h06, 32'h0);
    push("sh_05_ades", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 3'b001, 6'h05, 32'h0000_FFFF);
    ld("lw_04_unchanged", 3'b000, 6'h04, 32'h5566_7788);

    st(3'b000, 6'h08, 32'h1111_1111);
    push("rbw_old_data", 1'b1, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
    cyc(1'b1, 1'b1, 3'b000, 6'h08, 32'hDEAD_BEEF);
    ld("lw_08_new", 3'b000, 6'h08, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b0, 3'b000, 6'h00, 32'h0);
    chk("idle_rvalid", 32'(rvalid), 32'd0);
    chk("idle_rdata_hold", rdata, 32'hDEAD_BEEF);

    clr = 1'b1;
    push("clr_same_cycle", 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_AB78);
    cyc(1'b0, 1'b1, 3'b000, 6'h10, 32'h0);
    clr = 1'b0;
    chk("clr_ready_low", 32'(ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_clear_ready", 32'(ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("mid_reset_ready", 32'(ready), 32'd0);
    chk("mid_reset_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    // Requests held during the clear must be ignored.
    we = 1'b1; re = 1'b1; op = 3'b000; addr = 6'h06; wdata = 32'hFFFF_FFFF;
    reset = 1'b1;
    wait_ready(n);
    we = 1'b0; re = 1'b0;
    chk("restart_clear_len", 32'(n), 32'd16);

    for (int i = 0; i < 16; i++) begin
      ld($sformatf("cleared_word_%0d", i), 3'b000, 6'(i * 4), 32'h0);
    end

    repeat (3) @(posedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: got no response, required rvalid=%0b adel=%0b ades=%0b",
               e.name, e.rv, e.adel, e.ades);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_ext.md
# dm_ext

Parametrised data memory for the pipelined MIPS core's MEM stage, successor to the fixed 1024-word word-only DM. Adds byte/halfword stores, sign/zero-extending loads, misalignment exceptions, a registered read port, and a hardware clear sequencer that zeroes the array one word per cycle after reset or on request. Sits between the EX/MEM pipeline register and the MEM/WB register; `rdata` feeds WB directly.

## Interface
- `ADDR_W`, default 10: word-address bits; depth = 2**ADDR_W words of 32 bits.
- `clk` input 1: sole clock, all state changes on rising edge.
- `reset` input 1: asynchronous, active-low; low forces the reset state below.
- `clr` input 1: synchronous request to re-zero the array; sampled only in READY.
- `addr` input ADDR_W+2: byte address; `addr[1:0]` selects the lane.
- `op` input 3: access type; 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101–111 treated as 000.
- `we` input 1: store request.
- `re` input 1: load request.
- `wdata` input 32: store data, right-aligned (`sb` uses [7:0], `sh` uses [15:0]).
- `pc` input 32: PC of the requesting instruction, trace use only.
- `rdata` output 32: extended load result.
- `rvalid` output 1: `rdata` holds a completed load.
- `ready` output 1: clear finished, requests accepted.
- `exc_adel` output 1: misaligned load, one-cycle pulse.
- `exc_ades` output 1: misaligned store, one-cycle pulse.

## Operation
- States: CLEAR, READY. `reset` low -> CLEAR, index 0, `ready`=0, `rdata`=0, `rvalid`=0, `exc_*`=0.
- CLEAR: each cycle writes 0 to word `index`, index+1; when index = 2**ADDR_W−1 is written, next state READY. `we`/`re` ignored (no write, no `rvalid`, no exceptions).
- READY: `clr`=1 -> CLEAR with index 0 next cycle; the request in the same cycle as `clr` is still serviced.
- Alignment: word needs `addr[1:0]`=00, half needs `addr[0]`=0, byte always aligned.
- Store (`we`, aligned): lane-merged write, little-endian (lane 0 = bits [7:0]); `sh` at `addr[1]`=1 writes [31:16]. Misaligned: no write, `exc_ades`=1 next cycle.
- Load (`re`, aligned): lane extracted, sign- or zero-extended per `op`, registered into `rdata`, `rvalid`=1. Misaligned: `rdata`=0, `rvalid`=0, `exc_adel`=1.
- `we` and `re` same cycle, same word: read returns pre-write contents (read-before-write).
- No `re` in a cycle: `rvalid` drops to 0 next cycle, `rdata` holds its last value.
- Reset asserted mid-clear or mid-access: immediate return to reset state; partial clear restarts from index 0.

## Timing
- Store commits at the rising edge where `we` is sampled; a load issued the next cycle sees it.
- Load latency 1: `rdata`/`rvalid` valid the cycle after `re`.
- Exceptions appear with the same 1-cycle latency as `rvalid`.
- Clear takes exactly 2**ADDR_W cycles; `ready` rises on the cycle after the last word is zeroed.
- Back-to-back loads and stores accepted every READY cycle; no stalls.

## Configuration
- `DM_TRACE_EN` defined: every committed store prints `@<pc>: *<byte address> <= <merged 32-bit word>` using `$display`, with the address word-aligned (low two bits zero) and both values as 8-digit hex. Clear-sequencer writes are not printed.
- Undefined: no trace logic; `pc` is unused.

## Structure
- `dm_pkg`: `op` encoding as an enum, state enum {CLEAR, READY}, lane/size helper constants.
- Sub-module `dm_load_ext`: combinational lane select plus sign/zero extension, reused by the WB-stage bypass.
- Array, clear FSM, store merge, and output registers live in `dm_ext`.

## Test plan
- Reset release with `ADDR_W`=4: `ready`=0 for 16 cycles, then 1; word load at 0x3C returns 0x00000000.
- Store 0x12345678 at 0x10, then `sb` 0xAB at 0x11: word load at 0x10 gives 0x1234AB78; `lb` at 0x11 gives 0xFFFFFFAB; `lbu` gives 0x000000AB.
- `sh` 0x8001 at 0x22: `lh` 0x22 gives 0xFFFF8001, `lhu` gives 0x00008001, word load at 0x20 gives 0x80010000.
- Word load at 0x06: `exc_adel`=1 for one cycle, `rvalid`=0. `sh` at 0x05: `exc_ades`=1, memory unchanged.
- Same-cycle `we` 0xDEADBEEF / `re` at 0x08 holding 0x11111111: `rdata`=0x11111111; a load the next cycle returns 0xDEADBEEF.
- Pulse `clr`, then drop `reset` at cycle 5 of the clear: `ready` stays 0; after `reset` release the full 16-cycle clear restarts and all words read 0.
